// File: rtl/i2c_rx_bit_ctrl.sv
// Bit-level receive controller for the I2C slave path: pin synchronisers, START/STOP
// detection, per-bit shift strobes to the SIPO, bit counting and ACK-slot SDA drive.
module i2c_rx_bit_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int BITS        = 8
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic       ack_en,
  output logic       bit_out,
  output logic       load,
  output logic       clear,
  output logic       byte_done,
  output logic       start_det,
  output logic       stop_det,
  output logic       sda_oe,
  output logic [3:0] bit_cnt,
  output logic       busy
);

  // state | meaning
  // IDLE  | bus not addressed, wait for START
  // RX    | sampling data bits on SCL rising edges
  // ACK   | driving SDA low through the acknowledge clock
  // NACK  | releasing SDA through the acknowledge clock, then back to IDLE
  typedef enum logic [1:0] {IDLE, RX, ACK, NACK} state_t;

  localparam logic [3:0] BITS_C = 4'(BITS);

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_q, sda_q;
  logic ev_rise, ev_fall, ev_start, ev_stop, sda_r;

  state_t     state_q, state_d;
  logic       bit_out_d, load_d, clear_d, byte_done_d, start_det_d, stop_det_d;
  logic       sda_oe_d, busy_d;
  logic [3:0] bit_cnt_d;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Events are registered once more so every strobe lands SYNC_STAGES+1 clocks after the pin.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      scl_sync <= '0;
      sda_sync <= '0;
      scl_q    <= 1'b0;
      sda_q    <= 1'b0;
      ev_rise  <= 1'b0;
      ev_fall  <= 1'b0;
      ev_start <= 1'b0;
      ev_stop  <= 1'b0;
      sda_r    <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
      ev_rise  <= ~scl_q & scl_s;
      ev_fall  <= scl_q & ~scl_s;
      ev_start <= scl_q & scl_s & sda_q & ~sda_s;
      ev_stop  <= scl_q & scl_s & ~sda_q & sda_s;
      sda_r    <= sda_s;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= IDLE;
      bit_out   <= 1'b0;
      load      <= 1'b0;
      clear     <= 1'b0;
      byte_done <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_oe    <= 1'b0;
      bit_cnt   <= 4'd0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_out   <= bit_out_d;
      load      <= load_d;
      clear     <= clear_d;
      byte_done <= byte_done_d;
      start_det <= start_det_d;
      stop_det  <= stop_det_d;
      sda_oe    <= sda_oe_d;
      bit_cnt   <= bit_cnt_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_out_d   = bit_out;
    load_d      = 1'b0;
    clear_d     = 1'b0;
    byte_done_d = load & (bit_cnt == BITS_C);
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    sda_oe_d    = sda_oe;
    bit_cnt_d   = bit_cnt;
    busy_d      = busy;
    if (ev_start) begin
      start_det_d = 1'b1;
      clear_d     = 1'b1;
      bit_cnt_d   = 4'd0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b1;
      state_d     = RX;
    end else if (ev_stop) begin
      stop_det_d = 1'b1;
      sda_oe_d   = 1'b0;
      bit_cnt_d  = 4'd0;
      busy_d     = 1'b0;
      state_d    = IDLE;
    end else begin
      case (state_q)
        RX: begin
          if (ev_fall && bit_cnt == BITS_C) begin
            if (ack_en) begin
              sda_oe_d = 1'b1;
              state_d  = ACK;
            end else begin
              state_d = NACK;
            end
          end else if (ev_rise && bit_cnt < BITS_C) begin
            bit_out_d = sda_r;
            load_d    = 1'b1;
            bit_cnt_d = bit_cnt + 4'd1;
          end
        end
        ACK: begin
          if (ev_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            clear_d   = 1'b1;
            state_d   = RX;
          end
        end
        NACK: begin
          if (ev_fall) begin
            bit_cnt_d = 4'd0;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_rx_bit_ctrl.sv
// Directed bench for i2c_rx_bit_ctrl: drives I2C frames on the raw pins and checks strobes,
// counters and ACK drive with immediate assertions against hand-derived values.
module tb_i2c_rx_bit_ctrl;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       scl_in = 1'b1;
  logic       sda_in = 1'b1;
  logic       ack_en = 1'b1;
  logic       bit_out, load, clear, byte_done, start_det, stop_det, sda_oe, busy;
  logic [3:0] bit_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  int load_cnt = 0, bdone_cnt = 0, clear_cnt = 0, start_cnt = 0, stop_cnt = 0;
  int clr_oe_fall = 0, stop_oe_fall = 0, viol = 0;
  logic [7:0] rx_byte = 8'h00;
  logic       load_p = 1'b0, clear_p = 1'b0, bdone_p = 1'b0, start_p = 1'b0, stop_p = 1'b0;
  logic       oe_p = 1'b0, bout_p = 1'b0;
  logic [3:0] cnt_p = 4'd0;

  int s_load, s_bdone, s_clear, s_start, s_stop, s_cof, s_sof;
  logic oe_all, oe_any;

  i2c_rx_bit_ctrl #(.SYNC_STAGES(2), .BITS(8)) dut (
    .clk(clk), .rst_(rst_), .scl_in(scl_in), .sda_in(sda_in), .ack_en(ack_en),
    .bit_out(bit_out), .load(load), .clear(clear), .byte_done(byte_done),
    .start_det(start_det), .stop_det(stop_det), .sda_oe(sda_oe), .bit_cnt(bit_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Event counters plus pulse-shape rules that must hold on every cycle.
  always @(negedge clk) begin
    if (load) begin
      load_cnt <= load_cnt + 1;
      rx_byte  <= {rx_byte[6:0], bit_out};
    end
    if (byte_done) bdone_cnt <= bdone_cnt + 1;
    if (clear)     clear_cnt <= clear_cnt + 1;
    if (start_det) start_cnt <= start_cnt + 1;
    if (stop_det)  stop_cnt  <= stop_cnt + 1;
    if (oe_p && !sda_oe && clear)    clr_oe_fall  <= clr_oe_fall + 1;
    if (oe_p && !sda_oe && stop_det) stop_oe_fall <= stop_oe_fall + 1;
    if ((load && load_p) || (clear && clear_p) || (byte_done && bdone_p) ||
        (start_det && start_p) || (stop_det && stop_p) || (load && clear) ||
        ((load_p && cnt_p == 4'd8) != byte_done) ||
        (rst_ && bit_out !== bout_p && !load))
      viol <= viol + 1;
    load_p  <= load;
    clear_p <= clear;
    bdone_p <= byte_done;
    start_p <= start_det;
    stop_p  <= stop_det;
    oe_p    <= sda_oe;
    bout_p  <= bit_out;
    cnt_p   <= bit_cnt;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_load = load_cnt; s_bdone = bdone_cnt; s_clear = clear_cnt;
    s_start = start_cnt; s_stop = stop_cnt; s_cof = clr_oe_fall; s_sof = stop_oe_fall;
  endtask

  task automatic send_bit(input logic b);
    wait_clk(H); sda_in = b;
    wait_clk(H); scl_in = 1'b1;
    wait_clk(2*H); scl_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic ack_slot();
    wait_clk(H); sda_in = 1'b1;
    wait_clk(H); scl_in = 1'b1;
    oe_all = 1'b1; oe_any = 1'b0;
    for (int i = 0; i < 2*H; i++) begin
      wait_clk(1);
      oe_all = oe_all & sda_oe;
      oe_any = oe_any | sda_oe;
    end
    scl_in = 1'b0;
    wait_clk(2*H);
  endtask

  task automatic do_start();
    wait_clk(H); sda_in = 1'b1;
    wait_clk(H); scl_in = 1'b1;
    wait_clk(2*H); sda_in = 1'b0;
    wait_clk(2*H); scl_in = 1'b0;
    wait_clk(H);
  endtask

  task automatic do_stop();
    wait_clk(H); sda_in = 1'b0;
    wait_clk(H); scl_in = 1'b1;
    wait_clk(2*H); sda_in = 1'b1;
    wait_clk(2*H);
  endtask

  initial begin
    // reset state
    wait_clk(3);
    chk("rst_outputs", {bit_out, load, clear, byte_done, start_det, stop_det, sda_oe, bit_cnt, busy}, 0);
    rst_ = 1'b1;
    wait_clk(10);
    chk("idle_busy", busy, 0);
    chk("idle_start", start_cnt, 0);

    // START, 0xA5, ACK, STOP
    snap();
    do_start();
    chk("a5_start_det", start_cnt - s_start, 1);
    chk("a5_busy", busy, 1);
    chk("a5_cnt0", bit_cnt, 0);
    send_byte(8'hA5);
    chk("a5_loads", load_cnt - s_load, 8);
    chk("a5_data", rx_byte, 8'hA5);
    chk("a5_byte_done", bdone_cnt - s_bdone, 1);
    chk("a5_cnt8", bit_cnt, 8);
    ack_slot();
    chk("a5_oe_high", oe_all, 1);
    chk("a5_oe_low", sda_oe, 0);
    chk("a5_cnt_after_ack", bit_cnt, 0);
    chk("a5_clears", clear_cnt - s_clear, 2);
    chk("a5_clear_at_oe_fall", clr_oe_fall - s_cof, 1);
    do_stop();
    chk("a5_stop_det", stop_cnt - s_stop, 1);
    chk("a5_busy_end", busy, 0);

    // Two bytes back-to-back
    snap();
    do_start();
    send_byte(8'h3C);
    chk("b2_data0", rx_byte, 8'h3C);
    ack_slot();
    chk("b2_oe0", oe_all, 1);
    chk("b2_cnt0", bit_cnt, 0);
    send_byte(8'hFF);
    chk("b2_data1", rx_byte, 8'hFF);
    ack_slot();
    chk("b2_oe1", oe_all, 1);
    chk("b2_cnt1", bit_cnt, 0);
    chk("b2_loads", load_cnt - s_load, 16);
    chk("b2_byte_done", bdone_cnt - s_bdone, 2);
    chk("b2_clears", clear_cnt - s_clear, 3);
    do_stop();

    // NACK byte, then SCL activity without START
    ack_en = 1'b0;
    snap();
    do_start();
    send_byte(8'h12);
    chk("nk_data", rx_byte, 8'h12);
    ack_slot();
    chk("nk_oe_never", oe_any, 0);
    chk("nk_busy", busy, 0);
    chk("nk_cnt", bit_cnt, 0);
    snap();
    send_byte(8'hF0);
    chk("nk_no_load", load_cnt - s_load, 0);
    ack_en = 1'b1;

    // Repeated START after 3 bits
    snap();
    do_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("rs_cnt3", bit_cnt, 3);
    do_start();
    chk("rs_start_det", start_cnt - s_start, 2);
    chk("rs_clears", clear_cnt - s_clear, 2);
    chk("rs_cnt0", bit_cnt, 0);
    chk("rs_no_byte_done", bdone_cnt - s_bdone, 0);
    snap();
    send_byte(8'h81);
    chk("rs_loads", load_cnt - s_load, 8);
    chk("rs_byte_done", bdone_cnt - s_bdone, 1);
    chk("rs_data", rx_byte, 8'h81);
    ack_slot();
    do_stop();

    // STOP during ACK
    do_start();
    send_byte(8'hC3);
    wait_clk(H); sda_in = 1'b0;
    wait_clk(H); scl_in = 1'b1;
    wait_clk(H);
    chk("sa_oe_in_ack", sda_oe, 1);
    snap();
    sda_in = 1'b1;
    wait_clk(2*H);
    chk("sa_stop_det", stop_cnt - s_stop, 1);
    chk("sa_oe_with_stop", stop_oe_fall - s_sof, 1);
    chk("sa_oe_low", sda_oe, 0);
    chk("sa_no_clear", clear_cnt - s_clear, 0);
    chk("sa_busy", busy, 0);

    // Reset mid-byte
    do_start();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    chk("rm_cnt5", bit_cnt, 5);
    chk("rm_busy", busy, 1);
    #2 rst_ = 1'b0;
    #1;
    chk("rm_async_zero", {bit_out, load, clear, byte_done, start_det, stop_det, sda_oe, bit_cnt, busy}, 0);
    wait_clk(4);
    rst_ = 1'b1;
    wait_clk(4);
    snap();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("rm_no_load", load_cnt - s_load, 0);
    chk("rm_idle_busy", busy, 0);
    do_start();
    snap();
    send_byte(8'h55);
    chk("rm_loads", load_cnt - s_load, 8);
    chk("rm_data", rx_byte, 8'h55);
    chk("rm_byte_done", bdone_cnt - s_bdone, 1);
    ack_slot();
    chk("rm_oe_high", oe_all, 1);
    do_stop();
    chk("rm_busy_end", busy, 0);

    chk("pulse_rules", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_rx_bit_ctrl.md
# i2c_rx_bit_ctrl

- Bit-level receive controller for the I2C slave path.
- Synchronises raw SCL/SDA, detects START/STOP, and samples SDA on each SCL rising edge.
- Feeds the downstream SIPO byte register with a serial bit, a one-cycle shift strobe and a clear strobe.
- Counts bits, flags byte completion and drives the ACK slot on SDA.

## Interface
- SYNC_STAGES, 2, synchroniser depth on scl_in/sda_in (≥2).
- BITS, 8, data bits per frame before the ACK slot (1..15).
- clk  in  1  system clock; must be ≥8× SCL frequency.
- rst_  in  1  reset, asynchronous, active-low.
- scl_in  in  1  raw SCL pin level.
- sda_in  in  1  raw SDA pin level.
- ack_en  in  1  1 = ACK the current byte, 0 = NACK; sampled on the SCL falling edge that ends bit BITS.
- bit_out  out  1  last sampled SDA bit (serial data to the SIPO).
- load  out  1  one-cycle shift strobe; bit_out is valid while load=1.
- clear  out  1  one-cycle strobe that resets the SIPO.
- byte_done  out  1  one-cycle pulse after the BITS-th load.
- start_det  out  1  one-cycle pulse per START or repeated START.
- stop_det  out  1  one-cycle pulse per STOP.
- sda_oe  out  1  1 = pull SDA low (ACK); open-drain enable.
- bit_cnt  out  4  bits received in the current frame (0..BITS).
- busy  out  1  high from START until STOP, or until a NACK frame ends.

## Operation
- Synchronisers: SYNC_STAGES flops per line give scl_s/sda_s; one further register gives scl_q/sda_q.
- Events, all evaluated on the same clk:
  - scl_rise = ~scl_q & scl_s; scl_fall = scl_q & ~scl_s.
  - start = scl_q & scl_s & sda_q & ~sda_s.
  - stop = scl_q & scl_s & ~sda_q & sda_s.
- States: IDLE, RX, ACK, NACK.
- IDLE: ignore SCL edges; start → RX.
- RX:
  - scl_rise → bit_out<=sda_s, load=1, bit_cnt+1.
  - scl_rise when bit_cnt becomes BITS → byte_done=1 on the following clk.
  - scl_fall with bit_cnt==BITS:
    - ack_en=1 → sda_oe<=1, state ACK.
    - ack_en=0 → state NACK.
- ACK: sda_oe held 1 through the 9th SCL high phase. On scl_fall: sda_oe<=0, bit_cnt<=0, clear=1, state RX.
- NACK: no drive. On scl_fall: bit_cnt<=0, busy<=0, state IDLE.
- start in any state, including mid-byte and ACK (repeated START):
  - start_det=1, clear=1, bit_cnt<=0, sda_oe<=0, busy<=1, state RX.
  - A partial byte is discarded with no byte_done.
- stop in any state: stop_det=1, sda_oe<=0, bit_cnt<=0, busy<=0, state IDLE. No clear pulse.
- Priority when events coincide: start/stop > scl_fall > scl_rise. start and stop are mutually exclusive by construction.
- SDA changes while SCL is low produce no event.
- load, clear, byte_done, start_det and stop_det are never high for more than one consecutive clk.
- load and clear are never high together.

## Timing
- Reset: every output 0 (bit_out=0, load=0, clear=0, byte_done=0, start_det=0, stop_det=0, sda_oe=0, bit_cnt=0, busy=0); state IDLE; all synchroniser and _q flops 0.
- rst_ asserted mid-transfer: all outputs 0 immediately (async); resume in IDLE. A bus in progress is ignored until the next START.
- Latency: a raw pin change first sampled at clk edge k produces its strobe output registered at edge k+SYNC_STAGES+1 (k+3 by default).
- bit_out changes only together with load and holds until the next load.
- byte_done asserts exactly 1 clk after the BITS-th load.
- sda_oe:
  - Rises 1 clk after the detected scl_fall ending bit BITS.
  - Falls 1 clk after the detected scl_fall ending the ACK clock.
  - Stays high for the entire 9th SCL high phase.
- clear after ACK coincides with the sda_oe falling edge.
- Outputs are all registered; no combinational path from pins.

## Test plan
- START, byte 0xA5 MSB-first, ack_en=1, STOP:
  - start_det 1 pulse, then 8 load pulses with bit_out 1,0,1,0,0,1,0,1.
  - byte_done 1 pulse after the 8th load; bit_cnt reaches 8.
  - sda_oe=1 throughout the 9th SCL high; clear pulses when sda_oe drops.
  - stop_det 1 pulse; busy 0 afterwards.
- Two bytes 0x3C, 0xFF back-to-back with ACK:
  - 16 loads, 2 byte_done pulses, clear between bytes, bit_cnt returns to 0 after each ACK.
- Byte 0x12 with ack_en=0:
  - sda_oe never 1; busy=0 and state IDLE after the 9th falling edge.
  - Further SCL clocks without START produce no load.
- Repeated START after 3 bits:
  - start_det and clear pulse, bit_cnt=0, no byte_done.
  - Next full byte 0x81 gives exactly 8 loads and 1 byte_done.
- STOP during ACK: sda_oe drops 1 clk after detection, stop_det pulses, no clear, busy=0.
- rst_ low mid-byte (after 5 bits), then release:
  - All outputs 0 immediately.
  - SCL pulses before a new START give no load; a new START plus byte 0x55 works normally.
